// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver/consumer side and uart_rx_fifo.
// master drives receiver bytes and consumer controls; slave is the FIFO itself.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_status;
  logic            pop;
  logic            clr_ovf;
  logic [7:0]      dout;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] level;
  logic            overflow;

  modport master (
    output rx_data, rx_status, pop, clr_ovf,
    input  dout, empty, full, level, overflow
  );

  modport slave (
    input  rx_data, rx_status, pop, clr_ovf,
    output dout, empty, full, level, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Captures one byte per rising rx_status edge into a circular FIFO read through a pop port.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read on pop.
module uart_rx_fifo #(
  parameter int ADDR_W = 4
) (
  input logic           sysclk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LVL_W = ADDR_W + 1;

  logic [2:0]        sync_q, sync_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [DEPTH];

  logic push_req, do_push, do_pop, drop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sync_d     = {sync_q[1:0], bus.rx_status};
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;

    // sync_q[1] is the synchronised strobe, sync_q[2] its previous value.
    push_req = sync_q[1] & ~sync_q[2];
    do_pop   = bus.pop & ~empty_q;
    do_push  = push_req & (~full_q | bus.pop);
    drop     = push_req & full_q & ~bus.pop;

    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    empty_d = (level_d == '0);
    full_d  = (level_d == LVL_W'(DEPTH));

    if (drop)             overflow_d = 1'b1;
    else if (bus.clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      sync_q     <= '1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and level decide which entries are valid.
  always_ff @(posedge sysclk) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.rx_data;
  end

`ifdef UART_RX_FIFO_FWFT_EN
  assign bus.dout = empty_q ? 8'h00 : mem_q[rd_ptr_q];
`else
  logic [7:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (do_pop) dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) dout_q <= 8'h00;
    else       dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
`endif

  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo against a queue-based behavioural model.
// The model dout rule follows UART_RX_FIFO_FWFT_EN when the same macro is defined for the bench.
module tb_uart_rx_fifo;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic sysclk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   hi_len, lo_len, pop_mod;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(.ADDR_W(ADDR_W)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  // Behavioural model: stored bytes in arrival order, edges at which a push is due.
  byte unsigned m_q[$];
  int           m_due[$];
  bit           m_ovf;
  bit           m_prev_rx;
  byte unsigned m_dout;
  int           m_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_due.delete();
    m_ovf     = 1'b0;
    m_prev_rx = 1'b1;
    m_dout    = 8'h00;
    m_cyc     = 0;
  endtask

  // One sysclk edge: a strobe first seen high at edge N writes its byte at edge N+2.
  task automatic model_step();
    bit push_now = 1'b0;
    bit dropped  = 1'b0;
    m_cyc++;
    if (bus.rx_status && !m_prev_rx) m_due.push_back(m_cyc + 2);
    m_prev_rx = bus.rx_status;
    if (m_due.size() > 0 && m_due[0] == m_cyc) begin
      void'(m_due.pop_front());
      push_now = 1'b1;
    end
    if (bus.pop && m_q.size() > 0) m_dout = m_q.pop_front();
    if (push_now) begin
      if (m_q.size() < DEPTH) m_q.push_back(bus.rx_data);
      else                    dropped = 1'b1;
    end
    if (dropped)          m_ovf = 1'b1;
    else if (bus.clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic compare();
    check("level",    32'(bus.level),    32'(m_q.size()));
    check("empty",    32'(bus.empty),    32'(m_q.size() == 0));
    check("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_FWFT_EN
    if (m_q.size() > 0) check("dout", 32'(bus.dout), 32'(m_q[0]));
`else
    check("dout", 32'(bus.dout), 32'(m_dout));
`endif
  endtask

  // Advance one edge, update the model, then compare away from the edge.
  task automatic tick();
    @(posedge sysclk);
    if (reset) model_reset();
    else       model_step();
    #1;
    compare();
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.rx_data   = d;
    bus.rx_status = 1'b1;
    repeat (3) tick();
    bus.rx_status = 1'b0;
    repeat (2) tick();
  endtask

  // Raise the strobe and assert pop (and optionally clr_ovf) exactly on the write edge.
  task automatic push_with(input logic [7:0] d, input logic with_pop, input logic with_clr);
    bus.rx_data   = d;
    bus.rx_status = 1'b1;
    repeat (2) tick();
    bus.pop     = with_pop;
    bus.clr_ovf = with_clr;
    tick();
    bus.pop       = 1'b0;
    bus.clr_ovf   = 1'b0;
    bus.rx_status = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    reset         = 1'b1;
    bus.rx_data   = 8'h00;
    bus.rx_status = 1'b1;
    bus.pop       = 1'b0;
    bus.clr_ovf   = 1'b0;
    model_reset();

    // Strobe held high through reset and after release must never push.
    repeat (3) tick();
    check("rst_level", bus.level, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_dout",  bus.dout,  8'h00);
    reset = 1'b0;
    repeat (100) tick();
    check("hold_high_level", bus.level, 0);
    check("hold_high_empty", bus.empty, 1);

    // Long strobe: one push, visible two edges after first sample.
    bus.rx_status = 1'b0;
    repeat (3) tick();
    bus.rx_data   = 8'h5A;
    bus.rx_status = 1'b1;
    tick();
    check("lat_edge_n",  bus.level, 0);
    tick();
    check("lat_edge_n1", bus.level, 0);
    tick();
    check("lat_edge_n2", bus.level, 1);
    repeat (37) tick();
    bus.rx_status = 1'b0;
    repeat (3) tick();
    check("long_pulse_one_push", bus.level, 1);
`ifdef UART_RX_FIFO_FWFT_EN
    check("fwft_5a", bus.dout, 8'h5A);
`endif
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
    check("pop_5a", bus.dout, 8'h5A);
`endif
    check("pop_5a_empty", bus.empty, 1);

    // Fill, overflow drop, drain in order.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
    check("fill_full",  bus.full,  1);
    check("fill_level", bus.level, 16);
    send_byte(8'hAA);
    check("drop_ovf",   bus.overflow, 1);
    check("drop_level", bus.level, 16);
    for (int i = 0; i < DEPTH; i++) begin
`ifdef UART_RX_FIFO_FWFT_EN
      check("drain_order", bus.dout, i);
`endif
      bus.pop = 1'b1;
      tick();
`ifndef UART_RX_FIFO_FWFT_EN
      check("drain_order", bus.dout, i);
`endif
    end
    bus.pop = 1'b0;
    tick();
    check("drain_empty", bus.empty, 1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("clr_ovf", bus.overflow, 0);

    // Push onto empty with coincident pop; then pop on empty alone.
    push_with(8'h33, 1'b1, 1'b0);
    check("empty_pushpop_level", bus.level, 1);
`ifdef UART_RX_FIFO_FWFT_EN
    check("empty_pushpop_fwft", bus.dout, 8'h33);
`endif
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check("pop_33", bus.dout, 8'h33);
    bus.pop = 1'b1;
    repeat (3) tick();
    bus.pop = 1'b0;
    check("underflow_level", bus.level, 0);
    check("underflow_empty", bus.empty, 1);
`ifndef UART_RX_FIFO_FWFT_EN
    check("underflow_dout", bus.dout, 8'h33);
`endif

    // Full with push and pop together: no overflow, oldest out.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i));
    push_with(8'h77, 1'b1, 1'b0);
    check("full_pushpop_level", bus.level, 16);
    check("full_pushpop_ovf",   bus.overflow, 0);
`ifdef UART_RX_FIFO_FWFT_EN
    check("full_pushpop_head", bus.dout, 8'h11);
`else
    check("full_pushpop_dout", bus.dout, 8'h10);
`endif
    // clr_ovf on the same edge as a drop: the drop wins.
    push_with(8'hBB, 1'b0, 1'b1);
    check("clr_vs_drop_ovf", bus.overflow, 1);

    // Async reset mid-stream at level 5 with overflow set.
    bus.pop = 1'b1;
    repeat (11) tick();
    bus.pop = 1'b0;
    check("pre_reset_level", bus.level, 5);
    reset = 1'b1;
    #1;
    check("async_rst_level", bus.level, 0);
    check("async_rst_empty", bus.empty, 1);
    check("async_rst_full",  bus.full, 0);
    check("async_rst_ovf",   bus.overflow, 0);
    check("async_rst_dout",  bus.dout, 8'h00);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();

    // Random pulses: a fill-heavy phase then a drain-heavy phase.
    for (int p = 0; p < 300; p++) begin
      hi_len  = $urandom_range(2, 6);
      lo_len  = $urandom_range(1, 5);
      pop_mod = (p < 150) ? 10 : 2;
      bus.rx_data   = 8'($urandom);
      bus.rx_status = 1'b1;
      for (int k = 0; k < hi_len + lo_len; k++) begin
        if (k == hi_len) bus.rx_status = 1'b0;
        bus.pop     = ($urandom_range(0, pop_mod) == 0);
        bus.clr_ovf = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    bus.pop     = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
